pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_pkg.sv | 40 ++++
 rtl/pipe_hazard_ctrl.sv | 98 +++++++++
 tb/tb_pipe_hazard_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard/issue controller:
// forwarding select encodings, FSM state encoding and the per-operand
// forwarding priority function.
package pipe_pkg;

  // Operand source select for the EX-stage ALU input muxes
  localparam logic [1:0] FWD_RF  = 2'b00;  // register file read data
  localparam logic [1:0] FWD_EXE = 2'b01;  // ALU result of the EX instruction
  localparam logic [1:0] FWD_MEM = 2'b10;  // ALU result of the MEM instruction
  localparam logic [1:0] FWD_MLD = 2'b11;  // load data of the MEM instruction

  // Issue FSM states
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Forward select for one source register. The youngest producer (EX)
  // wins over MEM. Register 0 is hard-wired to zero, so it never forwards.
  // An EX load cannot forward; that case is covered by the load-use stall.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       ewreg,
    input logic       em2reg,
    input logic [4:0] ern,
    input logic       mwreg,
    input logic       mm2reg,
    input logic [4:0] mrn
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (ewreg && !em2reg && (ern == src) && (ern != 5'd0)) begin
      sel = FWD_EXE;
    end else if (mwreg && !mm2reg && (mrn == src) && (mrn != 5'd0)) begin
      sel = FWD_MEM;
    end else if (mwreg && mm2reg && (mrn == src) && (mrn != 5'd0)) begin
      sel = FWD_MLD;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl.sv
// ID-stage hazard and issue controller: load-use stall detection, operand
// forwarding selects, multi-cycle multiply sequencing and a saturating
// stall-cycle counter for performance debug.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MUL_CYCLES = 4  // EX cycles a multiply occupies, 1..16
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [4:0]  drs,
  input  logic [4:0]  drt,
  input  logic        duse_rs,
  input  logic        duse_rt,
  input  logic        dmul,
  input  logic        ewreg,
  input  logic        em2reg,
  input  logic [4:0]  ern,
  input  logic        mwreg,
  input  logic        mm2reg,
  input  logic [4:0]  mrn,
  output logic        wpcir,
  output logic        dbubble,
  output logic [1:0]  fwda,
  output logic [1:0]  fwdb,
  output logic        ebusy,
  output logic [15:0] stall_cnt
);

  // Counter reload: the issue cycle itself is the first multiply cycle,
  // so the FSM only has to cover the remaining MUL_CYCLES-1.
  localparam logic [3:0] CNT_LOAD  = 4'(MUL_CYCLES - 1);
  localparam logic       MUL_MULTI = (MUL_CYCLES > 1);

  logic [0:0] state;
  logic [3:0] cnt;
  logic       lu;
  logic       busy;
  logic       stall;

  // Load-use hazard, stall/bubble generation and busy indication
  always_comb begin
    lu = ewreg && em2reg && (ern != 5'd0) &&
         ((duse_rs && (ern == drs)) || (duse_rt && (ern == drt)));
    busy    = (state == ST_BUSY);
    stall   = busy || lu;
    wpcir   = !stall;
    dbubble = stall;
    ebusy   = busy;
  end

  // Operand forwarding selects; independent of stall state
  always_comb begin
    fwda = fwd_sel(drs, ewreg, em2reg, ern, mwreg, mm2reg, mrn);
    fwdb = fwd_sel(drt, ewreg, em2reg, ern, mwreg, mm2reg, mrn);
  end

  // Multiply issue FSM: hold issue while the multiply occupies EX
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          // A multiply stuck behind a load-use hazard waits in ID
          if (dmul && !lu && MUL_MULTI) begin
            state <= ST_BUSY;
            cnt   <= CNT_LOAD;
          end
        end
        ST_BUSY: begin
          // cnt==0 cannot occur here; treating it as terminal avoids wrap
          if (cnt <= 4'd1) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  // Saturating count of cycles in which PC/IF-ID were held
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stall_cnt <= 16'd0;
    end else if (!wpcir && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl with hand-computed expectations.
module tb_pipe_hazard_ctrl;

  logic        clock;
  logic        resetn;
  logic [4:0]  drs, drt;
  logic        duse_rs, duse_rt, dmul;
  logic        ewreg, em2reg;
  logic [4:0]  ern;
  logic        mwreg, mm2reg;
  logic [4:0]  mrn;
  logic        wpcir, dbubble, ebusy;
  logic [1:0]  fwda, fwdb;
  logic [15:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  pipe_hazard_ctrl #(.MUL_CYCLES(4)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .drs       (drs),
    .drt       (drt),
    .duse_rs   (duse_rs),
    .duse_rt   (duse_rt),
    .dmul      (dmul),
    .ewreg     (ewreg),
    .em2reg    (em2reg),
    .ern       (ern),
    .mwreg     (mwreg),
    .mm2reg    (mm2reg),
    .mrn       (mrn),
    .wpcir     (wpcir),
    .dbubble   (dbubble),
    .fwda      (fwda),
    .fwdb      (fwdb),
    .ebusy     (ebusy),
    .stall_cnt (stall_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compare one observed value against its expected value
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    drs = 5'd0; drt = 5'd0; duse_rs = 1'b0; duse_rt = 1'b0; dmul = 1'b0;
    ewreg = 1'b0; em2reg = 1'b0; ern = 5'd0;
    mwreg = 1'b0; mm2reg = 1'b0; mrn = 5'd0;
  endtask

  initial begin
    clear_inputs();
    resetn = 1'b0;
    #1;
    // Reset state
    check("rst_wpcir", 32'(wpcir), 32'd1);
    check("rst_dbubble", 32'(dbubble), 32'd0);
    check("rst_fwda", 32'(fwda), 32'd0);
    check("rst_fwdb", 32'(fwdb), 32'd0);
    check("rst_ebusy", 32'(ebusy), 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    tick();
    tick();
    resetn = 1'b1;
    tick();

    // Forwarding from EX ALU, priority over MEM
    drs = 5'd5; duse_rs = 1'b1; ewreg = 1'b1; ern = 5'd5;
    #1;
    check("fwd_ex_fwda", 32'(fwda), 32'd1);
    check("fwd_ex_wpcir", 32'(wpcir), 32'd1);
    mwreg = 1'b1; mrn = 5'd5;
    #1;
    check("fwd_ex_over_mem", 32'(fwda), 32'd1);
    ewreg = 1'b0;
    #1;
    check("fwd_mem_alu", 32'(fwda), 32'd2);
    mm2reg = 1'b1;
    #1;
    check("fwd_mem_load", 32'(fwda), 32'd3);
    // rt path on its own register
    clear_inputs();
    drt = 5'd9; drs = 5'd4; ewreg = 1'b1; ern = 5'd9; mwreg = 1'b1; mrn = 5'd4;
    #1;
    check("fwd_rt_ex", 32'(fwdb), 32'd1);
    check("fwd_rs_mem", 32'(fwda), 32'd2);

    // Load-use on rt: one stall, then load data forwarded from MEM
    clear_inputs();
    ewreg = 1'b1; em2reg = 1'b1; ern = 5'd7; drt = 5'd7; duse_rt = 1'b0;
    #1;
    check("lu_unused_rt_wpcir", 32'(wpcir), 32'd1);
    duse_rt = 1'b1;
    #1;
    check("lu_wpcir", 32'(wpcir), 32'd0);
    check("lu_dbubble", 32'(dbubble), 32'd1);
    check("lu_stall_cnt0", 32'(stall_cnt), 32'd0);
    tick();
    check("lu_stall_cnt1", 32'(stall_cnt), 32'd1);
    ewreg = 1'b0; em2reg = 1'b0; ern = 5'd0;
    mwreg = 1'b1; mm2reg = 1'b1; mrn = 5'd7;
    #1;
    check("lu_next_fwdb", 32'(fwdb), 32'd3);
    check("lu_next_wpcir", 32'(wpcir), 32'd1);
    check("lu_next_dbubble", 32'(dbubble), 32'd0);
    tick();
    check("lu_cnt_hold", 32'(stall_cnt), 32'd1);

    // Register 0 never forwards or stalls
    clear_inputs();
    ewreg = 1'b1; ern = 5'd0; drs = 5'd0; duse_rs = 1'b1;
    #1;
    check("r0_fwda", 32'(fwda), 32'd0);
    check("r0_wpcir", 32'(wpcir), 32'd1);
    em2reg = 1'b1;
    #1;
    check("r0_load_wpcir", 32'(wpcir), 32'd1);

    // Multiply: issue cycle advances, then exactly 3 busy cycles
    clear_inputs();
    dmul = 1'b1;
    #1;
    check("mul_issue_wpcir", 32'(wpcir), 32'd1);
    check("mul_issue_ebusy", 32'(ebusy), 32'd0);
    tick();
    dmul = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("mul_busy%0d_ebusy", i), 32'(ebusy), 32'd1);
      check($sformatf("mul_busy%0d_wpcir", i), 32'(wpcir), 32'd0);
      check($sformatf("mul_busy%0d_dbubble", i), 32'(dbubble), 32'd1);
      tick();
    end
    check("mul_done_ebusy", 32'(ebusy), 32'd0);
    check("mul_done_wpcir", 32'(wpcir), 32'd1);
    check("mul_stall_cnt", 32'(stall_cnt), 32'd4);

    // Multiply blocked by load-use: 1 stall then 3 busy cycles
    clear_inputs();
    dmul = 1'b1; drs = 5'd3; duse_rs = 1'b1; ewreg = 1'b1; em2reg = 1'b1; ern = 5'd3;
    #1;
    check("mullu_wpcir", 32'(wpcir), 32'd0);
    tick();
    check("mullu_not_issued", 32'(ebusy), 32'd0);
    check("mullu_stall_cnt", 32'(stall_cnt), 32'd5);
    ewreg = 1'b0; em2reg = 1'b0; ern = 5'd0; mwreg = 1'b1; mm2reg = 1'b1; mrn = 5'd3;
    #1;
    check("mullu_issue_wpcir", 32'(wpcir), 32'd1);
    check("mullu_issue_fwda", 32'(fwda), 32'd3);
    tick();
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("mullu_busy%0d_wpcir", i), 32'(wpcir), 32'd0);
      tick();
    end
    check("mullu_done_wpcir", 32'(wpcir), 32'd1);
    check("mullu_stall_cnt", 32'(stall_cnt), 32'd8);

    // Reset in the second busy cycle clears everything immediately
    dmul = 1'b1;
    tick();
    dmul = 1'b0;
    check("rb_busy1", 32'(ebusy), 32'd1);
    tick();
    check("rb_busy2", 32'(ebusy), 32'd1);
    resetn = 1'b0;
    #1;
    check("rb_ebusy", 32'(ebusy), 32'd0);
    check("rb_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rb_wpcir", 32'(wpcir), 32'd1);
    tick();
    resetn = 1'b1;
    tick();
    check("rb_after_ebusy", 32'(ebusy), 32'd0);
    check("rb_after_wpcir", 32'(wpcir), 32'd1);
    check("rb_after_stall_cnt", 32'(stall_cnt), 32'd0);

    // Long stall: counter saturates at FFFF
    clear_inputs();
    ewreg = 1'b1; em2reg = 1'b1; ern = 5'd2; drs = 5'd2; duse_rs = 1'b1;
    for (int i = 0; i < 65534; i++) begin
      @(posedge clock);
    end
    #1;
    check("sat_fffe", 32'(stall_cnt), 32'hFFFE);
    tick();
    check("sat_ffff", 32'(stall_cnt), 32'hFFFF);
    tick();
    check("sat_hold", 32'(stall_cnt), 32'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
